// File: rtl/pr_lsu_stage_if.sv
// Bundle of operand, result and LSQ request/response signals for pr_lsu_stage.
// slave: the stage itself. master: producer/consumer/LSQ environment.
interface pr_lsu_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] data_in1;
    logic [XLEN-1:0] data_in2;
    logic            data_valid_in1;
    logic            data_valid_in2;
    logic            data_in_ack1;
    logic            data_in_ack2;
    logic            uses_data_in1;
    logic            uses_data_in2;
    logic [XLEN-1:0] data_out;
    logic            data_valid_out;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            lsq_full;
    logic [XLEN-1:0] load_data;
    logic            load_complete;
    logic            misalign_err;

    modport slave (
        input  data_in1, data_in2, data_valid_in1, data_valid_in2,
        input  lsq_full, load_data, load_complete,
        output data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2,
        output data_out, data_valid_out,
        output addr, data, fn3, load, store, new_request, misalign_err
    );

    modport master (
        output data_in1, data_in2, data_valid_in1, data_valid_in2,
        output lsq_full, load_data, load_complete,
        input  data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2,
        input  data_out, data_valid_out,
        input  addr, data, fn3, load, store, new_request, misalign_err
    );
endinterface

// File: rtl/pr_lsu_stage.sv
// Load/store pipeline stage: gathers operands, forms an address, issues one
// request to the LSQ and returns a single result word.
// MODE 0 = passthrough of data_in2, 1 = load, 2 = store.
// Optional feature macro: PR_LSU_ALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses are trapped in ISSUE (no request, misalign_err pulse,
// result 0) instead of being sent to the LSQ.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for all used operands valid; acks them on accept
// ISSUE     | presenting addr/data/fn3 to the LSQ until it is not full
// WAIT_LOAD | load issued, waiting for load_complete
// OUTPUT    | data_valid_out high for this single cycle
module pr_lsu_stage #(
    parameter int                     XLEN        = 32,
    parameter int                     MODE        = 1,
    parameter logic [2:0]             FN3         = 3'b010,
    parameter logic signed [XLEN-1:0] ADDR_OFFSET = '0
) (
    input logic          clk,
    input logic          rst,
    pr_lsu_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOAD, OUTPUT} state_t;

    localparam logic USE1     = (MODE != 0);
    localparam logic USE2     = (MODE != 1);
    localparam logic IS_LOAD  = (MODE == 1);
    localparam logic IS_STORE = (MODE == 2);

    state_t          state;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] result_r;
    logic            valid_q;
    logic            ready;
    logic            accept;
    logic            misaligned;

    // Operands are ready once every input this mode consumes is valid.
    always_comb begin
        ready = (!USE1 || bus.data_valid_in1) && (!USE2 || bus.data_valid_in2);
    end

    // Acks are a same-cycle response to the accept; suppressed while in reset.
    assign accept           = (state == IDLE) && ready && !rst;
    assign bus.data_in_ack1 = accept && USE1;
    assign bus.data_in_ack2 = accept && USE2;
    assign bus.uses_data_in1 = USE1;
    assign bus.uses_data_in2 = USE2;

`ifdef PR_LSU_ALIGN_CHECK_EN
    logic misalign_q;

    // Alignment is judged on the latched address against the access size.
    always_comb begin
        misaligned = 1'b0;
        case (FN3[1:0])
            2'b01:   misaligned = addr_r[0];
            2'b10:   misaligned = |addr_r[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign bus.misalign_err = misalign_q;
`else
    assign misaligned       = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    assign bus.new_request    = (state == ISSUE) && !misaligned && !bus.lsq_full;
    assign bus.load           = (state == ISSUE) && IS_LOAD;
    assign bus.store          = (state == ISSUE) && IS_STORE;
    assign bus.fn3            = (state == ISSUE) ? FN3 : 3'b000;
    assign bus.addr           = addr_r;
    assign bus.data           = data_r;
    assign bus.data_out       = result_r;
    assign bus.data_valid_out = valid_q;

    // Transaction FSM with registered address, store data, result and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_r   <= '0;
            data_r   <= '0;
            result_r <= '0;
            valid_q  <= 1'b0;
`ifdef PR_LSU_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef PR_LSU_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ready) begin
                        addr_r <= bus.data_in1 + ADDR_OFFSET;
                        data_r <= bus.data_in2;
                        if (MODE == 0) begin
                            result_r <= bus.data_in2;
                            valid_q  <= 1'b1;
                            state    <= OUTPUT;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef PR_LSU_ALIGN_CHECK_EN
                    if (misaligned) begin
                        result_r   <= '0;
                        valid_q    <= 1'b1;
                        misalign_q <= 1'b1;
                        state      <= OUTPUT;
                    end else
`endif
                    if (!bus.lsq_full) begin
                        if (IS_STORE) begin
                            result_r <= data_r;
                            valid_q  <= 1'b1;
                            state    <= OUTPUT;
                        end else begin
                            state <= WAIT_LOAD;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (bus.load_complete) begin
                        result_r <= bus.load_data;
                        valid_q  <= 1'b1;
                        state    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_lsu_stage.sv
// Self-checking bench for pr_lsu_stage: one instance per MODE, a vector table
// driven through per-mode tasks, per-instance result scoreboards, and hand
// sequences for reset, stray load_complete and misalignment.
module tb_pr_lsu_stage;

    localparam int XLEN = 32;
    localparam logic [31:0] LD_OFF = 32'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pr_lsu_stage_if #(.XLEN(XLEN)) ipass ();
    pr_lsu_stage_if #(.XLEN(XLEN)) ild ();
    pr_lsu_stage_if #(.XLEN(XLEN)) ist ();

    pr_lsu_stage #(.XLEN(XLEN), .MODE(0), .FN3(3'b010), .ADDR_OFFSET(32'sd0))
        u_pass (.clk(clk), .rst(rst), .bus(ipass.slave));
    pr_lsu_stage #(.XLEN(XLEN), .MODE(1), .FN3(3'b010), .ADDR_OFFSET(32'sd8))
        u_ld (.clk(clk), .rst(rst), .bus(ild.slave));
    pr_lsu_stage #(.XLEN(XLEN), .MODE(2), .FN3(3'b010), .ADDR_OFFSET(32'sd0))
        u_st (.clk(clk), .rst(rst), .bus(ist.slave));

    logic [31:0] q_pass[$];
    logic [31:0] q_ld[$];
    logic [31:0] q_st[$];

    typedef struct {
        int          kind;      // 0 pass, 1 load, 2 store
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] ld;
        int          pre;       // store: cycles with only in1 valid
        int          full;      // store: cycles of lsq_full
        int          lat;       // load: idle WAIT_LOAD cycles
        logic [31:0] exp_addr;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ipass.data_valid_out === 1'b1) begin
            if (q_pass.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pass_unexpected_valid: got data_out %h expected no result", ipass.data_out);
            end else chk("pass_data_out", ipass.data_out, q_pass.pop_front());
        end
        if (!rst && ild.data_valid_out === 1'b1) begin
            if (q_ld.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL load_unexpected_valid: got data_out %h expected no result", ild.data_out);
            end else chk("load_data_out", ild.data_out, q_ld.pop_front());
        end
        if (!rst && ist.data_valid_out === 1'b1) begin
            if (q_st.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL store_unexpected_valid: got data_out %h expected no result", ist.data_out);
            end else chk("store_data_out", ist.data_out, q_st.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic run_pass(input vec_t v);
        bit got = 0;
        @(posedge clk); #1;
        ipass.data_in2 = v.in2; ipass.data_in1 = ~v.in2;
        ipass.data_valid_in2 = 1'b1; ipass.data_valid_in1 = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            chk("pass_ack1_never", 32'(ipass.data_in_ack1), 32'd0);
            if (ipass.data_in_ack2) got = 1;
        end
        chk("pass_ack2_seen", 32'(got), 32'd1);
        q_pass.push_back(v.exp_out);
        @(posedge clk); #1;
        ipass.data_valid_in2 = 1'b0; ipass.data_valid_in1 = 1'b0;
        @(negedge clk);
        chk("pass_valid_n1", 32'(ipass.data_valid_out), 32'd1);
        chk("pass_ack2_once", 32'(ipass.data_in_ack2), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pass_valid_one_cycle", 32'(ipass.data_valid_out), 32'd0);
    endtask

    task automatic run_load(input vec_t v);
        bit got = 0;
        @(posedge clk); #1;
        ild.data_in1 = v.in1; ild.data_valid_in1 = 1'b1; ild.data_valid_in2 = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ild.data_in_ack1) got = 1;
        end
        chk("load_ack1_seen", 32'(got), 32'd1);
        chk("load_ack2_never", 32'(ild.data_in_ack2), 32'd0);
        q_ld.push_back(v.exp_out);
        @(posedge clk); #1;
        ild.data_valid_in1 = 1'b0;
        @(negedge clk);
        chk("load_new_request", 32'(ild.new_request), 32'd1);
        chk("load_addr", ild.addr, v.exp_addr);
        chk("load_flag", 32'(ild.load), 32'd1);
        chk("load_store_flag", 32'(ild.store), 32'd0);
        chk("load_fn3", 32'(ild.fn3), 32'd2);
        @(posedge clk); #1;
        ild.data_valid_in1 = 1'b1;
        @(negedge clk);
        chk("load_request_once", 32'(ild.new_request), 32'd0);
        chk("load_flag_outside_issue", 32'(ild.load), 32'd0);
        chk("load_no_ack_busy", 32'(ild.data_in_ack1), 32'd0);
        for (int i = 0; i < v.lat; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("load_no_ack_wait", 32'(ild.data_in_ack1), 32'd0);
            chk("load_no_valid_wait", 32'(ild.data_valid_out), 32'd0);
        end
        @(posedge clk); #1;
        ild.load_complete = 1'b1; ild.load_data = v.ld; ild.data_valid_in1 = 1'b0;
        @(negedge clk);
        chk("load_no_valid_same", 32'(ild.data_valid_out), 32'd0);
        @(posedge clk); #1;
        ild.load_complete = 1'b0; ild.load_data = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("load_valid_after_complete", 32'(ild.data_valid_out), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_store(input vec_t v);
        bit got = 0;
        @(posedge clk); #1;
        ist.data_in1 = v.in1; ist.data_in2 = v.in2;
        ist.lsq_full = (v.full > 0);
        ist.data_valid_in1 = 1'b1; ist.data_valid_in2 = 1'b0;
        for (int i = 0; i < v.pre; i++) begin
            @(negedge clk);
            chk("store_partial_ack1", 32'(ist.data_in_ack1), 32'd0);
            chk("store_partial_ack2", 32'(ist.data_in_ack2), 32'd0);
            chk("store_partial_req", 32'(ist.new_request), 32'd0);
            @(posedge clk); #1;
        end
        ist.data_valid_in2 = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ist.data_in_ack1) got = 1;
        end
        chk("store_ack1_seen", 32'(got), 32'd1);
        chk("store_ack2_with_ack1", 32'(ist.data_in_ack2), 32'd1);
        q_st.push_back(v.exp_out);
        @(posedge clk); #1;
        ist.data_valid_in1 = 1'b0; ist.data_valid_in2 = 1'b0;
        for (int i = 0; i < v.full; i++) begin
            @(negedge clk);
            chk("store_req_held_full", 32'(ist.new_request), 32'd0);
            chk("store_addr_stable", ist.addr, v.exp_addr);
            @(posedge clk); #1;
        end
        ist.lsq_full = 1'b0;
        @(negedge clk);
        chk("store_new_request", 32'(ist.new_request), 32'd1);
        chk("store_flag", 32'(ist.store), 32'd1);
        chk("store_load_flag", 32'(ist.load), 32'd0);
        chk("store_data", ist.data, v.in2);
        chk("store_addr", ist.addr, v.exp_addr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("store_valid_n2", 32'(ist.data_valid_out), 32'd1);
        chk("store_req_outside_issue", 32'(ist.new_request), 32'd0);
        chk("store_flag_outside_issue", 32'(ist.store), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt_v, cnt_m, cnt_r;
        bit got;

        vecs[0] = '{0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{0, 32'h0, 32'h0000_0000, 32'h0, 0, 0, 0, 32'h0, 32'h0000_0000};
        vecs[2] = '{1, 32'h1000, 32'h0, 32'h55, 0, 0, 2, 32'h1000 + LD_OFF, 32'h55};
        vecs[3] = '{1, 32'hFFFF_FFF8, 32'h0, 32'hA5A5_0001, 0, 0, 0, 32'h0, 32'hA5A5_0001};
        vecs[4] = '{2, 32'h2000, 32'h7, 32'h0, 0, 4, 0, 32'h2000, 32'h7};
        vecs[5] = '{2, 32'h10, 32'hCAFE_F00D, 32'h0, 3, 0, 0, 32'h10, 32'hCAFE_F00D};
        vecs[6] = '{0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[7] = '{2, 32'hFFFF_FFFC, 32'h1, 32'h0, 0, 1, 0, 32'hFFFF_FFFC, 32'h1};

        ipass.data_in1 = '0; ipass.data_in2 = '0; ipass.data_valid_in1 = 0; ipass.data_valid_in2 = 0;
        ipass.lsq_full = 0; ipass.load_data = '0; ipass.load_complete = 0;
        ild.data_in1 = '0; ild.data_in2 = '0; ild.data_valid_in1 = 0; ild.data_valid_in2 = 0;
        ild.lsq_full = 0; ild.load_data = '0; ild.load_complete = 0;
        ist.data_in1 = '0; ist.data_in2 = '0; ist.data_valid_in1 = 0; ist.data_valid_in2 = 0;
        ist.lsq_full = 0; ist.load_data = '0; ist.load_complete = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pass_valid", 32'(ipass.data_valid_out), 32'd0);
        chk("rst_pass_data_out", ipass.data_out, 32'h0);
        chk("rst_load_addr", ild.addr, 32'h0);
        chk("rst_load_req", 32'(ild.new_request), 32'd0);
        chk("rst_load_flag", 32'(ild.load), 32'd0);
        chk("rst_store_flag", 32'(ist.store), 32'd0);
        chk("rst_store_data", ist.data, 32'h0);
        chk("rst_misalign", 32'(ild.misalign_err), 32'd0);
        chk("uses_pass", 32'({ipass.uses_data_in1, ipass.uses_data_in2}), 32'd1);
        chk("uses_load", 32'({ild.uses_data_in1, ild.uses_data_in2}), 32'd2);
        chk("uses_store", 32'({ist.uses_data_in1, ist.uses_data_in2}), 32'd3);

        for (int i = 0; i < 8; i++) begin
            case (vecs[i].kind)
                0:       run_pass(vecs[i]);
                1:       run_load(vecs[i]);
                default: run_store(vecs[i]);
            endcase
        end

        // Stray load_complete while idle must not produce a result.
        @(posedge clk); #1;
        ild.load_complete = 1'b1; ild.load_data = 32'h1234_5678;
        @(posedge clk); #1;
        ild.load_complete = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cnt_v += int'(ild.data_valid_out);
        end
        chk("stray_complete_no_valid", 32'(cnt_v), 32'd0);

        // Reset while waiting for a load abandons it.
        @(posedge clk); #1;
        ild.data_in1 = 32'h3000; ild.data_valid_in1 = 1'b1;
        @(negedge clk);
        chk("rstmid_ack", 32'(ild.data_in_ack1), 32'd1);
        @(posedge clk); #1;
        ild.data_valid_in1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ild.load_complete = 1'b1; ild.load_data = 32'h99;
        @(negedge clk);
        chk("rstmid_addr", ild.addr, 32'h0);
        chk("rstmid_data_out", ild.data_out, 32'h0);
        chk("rstmid_req", 32'(ild.new_request), 32'd0);
        chk("rstmid_load", 32'(ild.load), 32'd0);
        @(posedge clk); #1;
        ild.load_complete = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt_v += int'(ild.data_valid_out);
        end
        chk("rstmid_no_valid", 32'(cnt_v), 32'd0);

        // Word load whose final address is 0x1002.
        @(posedge clk); #1;
        ild.data_in1 = 32'h1002 - LD_OFF; ild.data_valid_in1 = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ild.data_in_ack1) got = 1;
        end
        chk("mis_ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        ild.data_valid_in1 = 1'b0;
`ifdef PR_LSU_ALIGN_CHECK_EN
        q_ld.push_back(32'h0);
        cnt_v = 0; cnt_m = 0; cnt_r = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cnt_v += int'(ild.data_valid_out);
            cnt_m += int'(ild.misalign_err);
            cnt_r += int'(ild.new_request);
        end
        chk("mis_no_request", 32'(cnt_r), 32'd0);
        chk("mis_err_one_cycle", 32'(cnt_m), 32'd1);
        chk("mis_valid_one_cycle", 32'(cnt_v), 32'd1);
`else
        q_ld.push_back(32'h77);
        @(negedge clk);
        chk("mis_off_request", 32'(ild.new_request), 32'd1);
        chk("mis_off_addr", ild.addr, 32'h1002);
        @(posedge clk); #1;
        ild.load_complete = 1'b1; ild.load_data = 32'h77;
        @(posedge clk); #1;
        ild.load_complete = 1'b0;
        cnt_v = 0; cnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cnt_v += int'(ild.data_valid_out);
            cnt_m += int'(ild.misalign_err);
        end
        chk("mis_off_valid", 32'(cnt_v), 32'd1);
        chk("mis_off_err_tied", 32'(cnt_m), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("q_pass_drained", 32'(q_pass.size()), 32'd0);
        chk("q_load_drained", 32'(q_ld.size()), 32'd0);
        chk("q_store_drained", 32'(q_st.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pr_lsu_stage.md
PR_LSU_STAGE -- requirements
Module: pr_lsu_stage

Interface
REQ-001 Parameter MODE, default 1, operation: 0 = passthrough, 1 = load, 2 = store.
REQ-002 Parameter FN3, default 3'b010, access size/sign code driven on fn3.
REQ-003 Parameter ADDR_OFFSET, default 0, signed XLEN-bit immediate added to data_in1 to form addr.
REQ-004 clk  in  1  clock; all logic rising-edge, one clock domain.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 data_in1, data_in2  in  XLEN  operand words; data_valid_in1, data_valid_in2  in  1  operand valid.
REQ-007 data_out  out  XLEN  result word; data_valid_out  out  1  result valid.
REQ-008 data_in_ack1, data_in_ack2  out  1  operand consumed this cycle.
REQ-009 uses_data_in1, uses_data_in2  out  1  static operand-usage flags.
REQ-010 addr, data  out  XLEN; fn3  out  3; load, store, new_request  out  1; lsq_full  in  1: LSQ request port.
REQ-011 load_data  in  XLEN, load_complete  in  1: LSQ load response.
REQ-012 misalign_err  out  1  misaligned-access pulse.

Function
REQ-013 uses_data_in1 = (MODE!=0); uses_data_in2 = (MODE!=1); both constant.
REQ-014 States IDLE, ISSUE, WAIT_LOAD, OUTPUT; exactly one active per cycle.
REQ-015 IDLE: operands ready when every used input has valid high; on ready, ack each used input for that cycle only, latch addr_r = data_in1 + ADDR_OFFSET (mod 2^XLEN) and data_r = data_in2, go ISSUE (MODE 1/2) or OUTPUT (MODE 0).
REQ-016 Acks are never asserted outside IDLE, never for an unused input, and never while any used input is invalid.
REQ-017 ISSUE: new_request = !lsq_full; addr, data, fn3=FN3, load=(MODE==1), store=(MODE==2) held stable; on lsq_full stay in ISSUE.
REQ-018 ISSUE with new_request: MODE 1 -> WAIT_LOAD; MODE 2 -> OUTPUT with result = data_r.
REQ-019 WAIT_LOAD: on load_complete latch load_data as result, go OUTPUT; load_complete in any other state is ignored.
REQ-020 OUTPUT: data_valid_out high exactly one cycle with data_out = result, then IDLE; data_out holds last result otherwise.
REQ-021 Latency: passthrough accept cycle N -> valid N+1; store accept N, issue N+1 (lsq not full) -> valid N+2; load valid one cycle after load_complete.
REQ-022 Outside ISSUE, new_request, load and store are 0.
REQ-023 One transaction in flight; inputs presented in non-IDLE states are not acknowledged and are held by the producer.

Reset
REQ-024 rst forces IDLE; data_out, addr, data, result registers 0; all valid/ack/request/load/store/misalign_err outputs 0 in the cycle after rst is sampled.
REQ-025 Reset mid-transaction abandons it; a subsequent load_complete produces no output.

Configuration
REQ-026 Macro PR_LSU_ALIGN_CHECK_EN defined: in ISSUE, an addr misaligned for FN3[1:0] (half: bit0; word: bits[1:0]) issues no request, pulses misalign_err one cycle, goes OUTPUT with result 0.
REQ-027 PR_LSU_ALIGN_CHECK_EN undefined: no check, all addresses issued, misalign_err tied 0.

Verification
REQ-028 MODE=0, data_in2=32'hDEADBEEF valid cycle 5 -> ack2 cycle 5 only, ack1 never, data_valid_out cycle 6 with 32'hDEADBEEF.
REQ-029 MODE=1, ADDR_OFFSET=8, in1=32'h1000 -> addr=32'h1008, load=1, new_request one cycle; load_complete with 32'h55 three cycles later -> data_out=32'h55 next cycle.
REQ-030 MODE=2, lsq_full high 4 cycles, in1=32'h2000, in2=32'h7 -> new_request held 0 four cycles, then one request with store=1, data=32'h7, addr stable throughout.
REQ-031 MODE=1, rst asserted in WAIT_LOAD, then load_complete -> no data_valid_out, all outputs 0.
REQ-032 PR_LSU_ALIGN_CHECK_EN, MODE=1, FN3=3'b010, in1=32'h1002 -> no new_request, misalign_err one cycle, data_out=0 valid.
REQ-033 MODE=2, data_valid_in1 only high -> no ack, no request until data_valid_in2 also high.
